mac_frame: RTL and testbench

- Parametrised successor to the single-channel multiply-accumulate cell.
- Accumulates a frame of k*x products (dot product) behind a valid/ready input handshake. Emits one result per frame on a valid/ready output.
- Adds signed/unsigned mode, guard bits, output saturation with overflow flag, and frame termination by count or by in_last.
- Sits between sample/coefficient sources and downstream filter/decimation logic.

---
 rtl/mac_pkg.sv | 55 +++++
 rtl/mac_frame_mult.sv | 47 ++++
 rtl/mac_frame.sv | 141 ++++++++++++++
 tb/tb_mac_frame.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
// Shared types and helpers for the mac_frame multiply-accumulate block.
//   state_t  : frame controller states (ACC, FLUSH, HOLD)
//   fmt_t    : formatted result (up to 64 bits) plus range-overflow flag
//   sat_fmt  : range check and optional clamp of a wide accumulator sum
//   AW, CW   : accumulator and counter widths of the default configuration
// ---------------------------------------------------------------------------
package mac_pkg;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Widths for the default parameter set (WIDTH=16, GUARD=8, LEN=8).
    // mac_frame derives its own widths from its actual parameters.
    localparam int AW = 2 * 16 + 8;
    localparam int CW = $clog2(8 + 1);

    typedef struct packed {
        logic [63:0] res;
        logic        ovf;
    } fmt_t;

    // The sum arrives already sign- or zero-extended to 128 bits, so one
    // signed comparison covers both operand modes. rw is the result width
    // (2*WIDTH, at most 64).
    function automatic fmt_t sat_fmt(input logic signed [127:0] sum,
                                     input int                  rw,
                                     input bit                  sgn,
                                     input bit                  sat);
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        fmt_t                f;
        if (sgn) begin
            hi = (128'sd1 <<< (rw - 1)) - 128'sd1;
            lo = -(128'sd1 <<< (rw - 1));
        end else begin
            hi = (128'sd1 <<< rw) - 128'sd1;
            lo = 128'sd0;
        end
        f.ovf = (sum > hi) || (sum < lo);
        if (sat && (sum > hi)) begin
            f.res = hi[63:0];
        end else if (sat && (sum < lo)) begin
            f.res = lo[63:0];
        end else begin
            f.res = sum[63:0];
        end
        return f;
    endfunction

endpackage

// File: rtl/mac_frame_mult.sv
// ---------------------------------------------------------------------------
// mac_mult_stage
// Registered k*x multiplier with a valid flag travelling alongside.
//   clk, reset (async, active-low), ena (low freezes the stage)
//   accept     : a sample is taken this edge
//   k, x       : operands (signed or unsigned per SIGNED)
//   prod       : registered 2*WIDTH-bit product
//   prod_vld   : prod holds a product accepted at the previous enabled edge
// ---------------------------------------------------------------------------
module mac_mult_stage #(
    parameter int WIDTH  = 16,
    parameter int SIGNED = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ena,
    input  logic               accept,
    input  logic [WIDTH-1:0]   k,
    input  logic [WIDTH-1:0]   x,
    output logic [2*WIDTH-1:0] prod,
    output logic               prod_vld
);

    logic [2*WIDTH-1:0] k_ext;
    logic [2*WIDTH-1:0] x_ext;
    logic [2*WIDTH-1:0] prod_next;

    // Extending both operands to full width first makes the low 2*WIDTH bits
    // of a plain multiply correct for both signed and unsigned operands.
    assign k_ext     = {{WIDTH{(SIGNED != 0) && k[WIDTH-1]}}, k};
    assign x_ext     = {{WIDTH{(SIGNED != 0) && x[WIDTH-1]}}, x};
    assign prod_next = k_ext * x_ext;

    // Stage 1: multiply
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod     <= '0;
            prod_vld <= 1'b0;
        end else if (ena) begin
            prod_vld <= accept;
            if (accept) begin
                prod <= prod_next;
            end
        end
    end

endmodule

// File: rtl/mac_frame.sv
// ---------------------------------------------------------------------------
// mac_frame
// Frame dot-product accumulator: accumulates k*x over a frame of up to LEN
// samples (ended by count or in_last), then presents one formatted result.
//   clk, reset (async, active-low), ena (low freezes all state)
//   in_valid/in_ready, k, x, in_last : sample input handshake
//   out_valid/out_ready              : result output handshake
//   acc_out   : 2*WIDTH-bit result (clamped when SAT=1, truncated otherwise)
//   out_ovf   : accumulated sum was outside the 2*WIDTH result range
//   out_count : samples in the frame (1..LEN)
// ---------------------------------------------------------------------------
module mac_frame
    import mac_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int GUARD  = 8,
    parameter int LEN    = 8,
    parameter int SIGNED = 1,
    parameter int SAT    = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ena,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           k,
    input  logic [WIDTH-1:0]           x,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*WIDTH-1:0]         acc_out,
    output logic                       out_ovf,
    output logic [$clog2(LEN+1)-1:0]   out_count
);

    localparam int PW    = 2 * WIDTH;
    localparam int ACC_W = PW + GUARD;
    localparam int CNT_W = $clog2(LEN + 1);

    // Guard bits must cover LEN full-scale products so acc never wraps.
    generate
        if (LEN < 1 || GUARD < 1 || GUARD > 64 || LEN > (2 ** GUARD)) begin : g_len_chk
            $error("mac_frame: need 1 <= LEN <= 2**GUARD and 1 <= GUARD <= 64");
        end
        if (WIDTH < 1 || WIDTH > 32) begin : g_width_chk
            $error("mac_frame: WIDTH must be 1..32");
        end
    endgenerate

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   frame_cnt;
    logic [PW-1:0]      prod_p1;
    logic               vld_p1;
    logic               accept;
    logic               last;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   sum;
    logic [127:0]       sum_wide;
    fmt_t               fmt;

    assign in_ready = ena && (state == ACC);
    assign accept   = in_valid && in_ready;
    assign last     = in_last || (cnt == CNT_W'(LEN - 1));

    mac_mult_stage #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_mult (
        .clk      (clk),
        .reset    (reset),
        .ena      (ena),
        .accept   (accept),
        .k        (k),
        .x        (x),
        .prod     (prod_p1),
        .prod_vld (vld_p1)
    );

    assign prod_ext = {{GUARD{(SIGNED != 0) && prod_p1[PW-1]}}, prod_p1};
    assign sum      = acc + prod_ext;
    assign sum_wide = {{(128 - ACC_W){(SIGNED != 0) && sum[ACC_W-1]}}, sum};
    assign fmt      = sat_fmt(sum_wide, PW, SIGNED != 0, SAT != 0);

    generate
        if (PW < 64) begin : g_res_unused
            logic unused_res;
            assign unused_res = &{1'b0, fmt.res[63:PW]};
        end
    endgenerate

    // Stage 2: accumulate and frame control
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ACC;
            acc       <= '0;
            cnt       <= '0;
            frame_cnt <= '0;
            out_valid <= 1'b0;
            acc_out   <= '0;
            out_ovf   <= 1'b0;
            out_count <= '0;
        end else if (ena) begin
            if (vld_p1) begin
                acc <= sum;
            end
            unique case (state)
                ACC: begin
                    if (accept) begin
                        if (last) begin
                            cnt       <= '0;
                            frame_cnt <= cnt + 1'b1;
                            state     <= FLUSH;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    // The last product is still in prod_p1; fold it in here
                    // rather than waiting a cycle for acc to absorb it.
                    acc_out   <= fmt.res[PW-1:0];
                    out_ovf   <= fmt.ovf;
                    out_count <= frame_cnt;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_frame.sv
// ---------------------------------------------------------------------------
// tb_mac_frame
// Three mac_frame instances (signed+sat, signed+wrap, unsigned+sat) driven by
// the same stimulus, compared every cycle with a frame-level reference model,
// plus literal expectations on directed frames.
// ---------------------------------------------------------------------------
module tb_mac_frame;

    localparam int LEN = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ena = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] k = 16'd0;
    logic [15:0] x = 16'd0;

    logic        in_ready_o [3];
    logic        out_valid_o[3];
    logic        ovf_o      [3];
    logic [31:0] acc_o      [3];
    logic [3:0]  cnt_o      [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_frame #(.WIDTH(16), .GUARD(8), .LEN(LEN), .SIGNED(1), .SAT(1)) dut_ss (
        .clk(clk), .reset(reset), .ena(ena), .in_valid(in_valid), .in_ready(in_ready_o[0]),
        .k(k), .x(x), .in_last(in_last), .out_valid(out_valid_o[0]), .out_ready(out_ready),
        .acc_out(acc_o[0]), .out_ovf(ovf_o[0]), .out_count(cnt_o[0]));

    mac_frame #(.WIDTH(16), .GUARD(8), .LEN(LEN), .SIGNED(1), .SAT(0)) dut_sw (
        .clk(clk), .reset(reset), .ena(ena), .in_valid(in_valid), .in_ready(in_ready_o[1]),
        .k(k), .x(x), .in_last(in_last), .out_valid(out_valid_o[1]), .out_ready(out_ready),
        .acc_out(acc_o[1]), .out_ovf(ovf_o[1]), .out_count(cnt_o[1]));

    mac_frame #(.WIDTH(16), .GUARD(8), .LEN(LEN), .SIGNED(0), .SAT(1)) dut_us (
        .clk(clk), .reset(reset), .ena(ena), .in_valid(in_valid), .in_ready(in_ready_o[2]),
        .k(k), .x(x), .in_last(in_last), .out_valid(out_valid_o[2]), .out_ready(out_ready),
        .acc_out(acc_o[2]), .out_ovf(ovf_o[2]), .out_count(cnt_o[2]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    logic [15:0] qk[$];
    logic [15:0] qx[$];
    int          phase = 0;          // 0 taking samples, 1 result pending, 2 result shown
    logic        m_valid = 1'b0;
    logic [31:0] m_res[3];
    logic        m_ovf[3];
    logic [3:0]  m_cnt = 4'd0;
    logic [31:0] p_res[3];
    logic        p_ovf[3];
    logic [3:0]  p_cnt = 4'd0;

    function automatic void eval_frame();
        for (int c = 0; c < 3; c++) begin
            bit     sgn = (c != 2);
            bit     sat = (c != 1);
            longint s = 0;
            longint hi;
            longint lo;
            for (int i = 0; i < qk.size(); i++) begin
                if (sgn) s += longint'($signed(qk[i])) * longint'($signed(qx[i]));
                else     s += longint'(qk[i]) * longint'(qx[i]);
            end
            hi = sgn ? 64'sh7FFF_FFFF : 64'sh FFFF_FFFF;
            lo = sgn ? -64'sh8000_0000 : 64'sh0;
            p_ovf[c] = (s > hi) || (s < lo);
            if (sat && s > hi)      p_res[c] = hi[31:0];
            else if (sat && s < lo) p_res[c] = lo[31:0];
            else                    p_res[c] = s[31:0];
        end
        p_cnt = 4'(qk.size());
        qk.delete();
        qx.delete();
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            qk.delete();
            qx.delete();
            phase   = 0;
            m_valid = 1'b0;
            m_cnt   = 4'd0;
            for (int c = 0; c < 3; c++) begin
                m_res[c] = 32'd0;
                m_ovf[c] = 1'b0;
            end
        end else if (ena) begin
            case (phase)
                0: if (in_valid) begin
                    qk.push_back(k);
                    qx.push_back(x);
                    if (in_last || qk.size() == LEN) begin
                        eval_frame();
                        phase = 1;
                    end
                end
                1: begin
                    m_valid = 1'b1;
                    m_res   = p_res;
                    m_ovf   = p_ovf;
                    m_cnt   = p_cnt;
                    phase   = 2;
                end
                default: if (out_ready) begin
                    m_valid = 1'b0;
                    phase   = 0;
                end
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    bit cmp_on = 1'b0;
    always @(negedge clk) begin
        if (cmp_on) begin
            for (int c = 0; c < 3; c++) begin
                chk($sformatf("in_ready[%0d]", c), 64'(in_ready_o[c]), 64'(ena && phase == 0));
                chk($sformatf("out_valid[%0d]", c), 64'(out_valid_o[c]), 64'(m_valid));
                chk($sformatf("acc_out[%0d]", c), 64'(acc_o[c]), 64'(m_res[c]));
                chk($sformatf("out_ovf[%0d]", c), 64'(ovf_o[c]), 64'(m_ovf[c]));
                chk($sformatf("out_count[%0d]", c), 64'(cnt_o[c]), 64'(m_cnt));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] kk, input logic [15:0] xx, input logic lst);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        k = kk; x = xx; in_last = lst; in_valid = 1'b1;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = ena && (phase == 0);
            n++;
            if (!ok) tick();
        end
        if (!ok) chk("send_timeout", 64'd1, 64'd0);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_out(input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2,
                              input logic o0, input logic o1, input logic o2, input int cnt);
        int n;
        n = 0;
        @(negedge clk);
        while (out_valid_o[0] !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("result_wait", 64'(out_valid_o[0]), 64'd1);
        chk("lit_res_ss", 64'(acc_o[0]), 64'(r0));
        chk("lit_res_sw", 64'(acc_o[1]), 64'(r1));
        chk("lit_res_us", 64'(acc_o[2]), 64'(r2));
        chk("lit_ovf_ss", 64'(ovf_o[0]), 64'(o0));
        chk("lit_ovf_sw", 64'(ovf_o[1]), 64'(o1));
        chk("lit_ovf_us", 64'(ovf_o[2]), 64'(o2));
        chk("lit_count", 64'(cnt_o[0]), 64'(cnt));
        chk("lit_hold_ready", 64'(in_ready_o[0]), 64'd0);
        chk("model_res", 64'(m_res[0]), 64'(r0));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        repeat (3) tick();
        cmp_on = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid_o[0]), 64'd0);
        chk("rst_acc_out", 64'(acc_o[0]), 64'd0);
        chk("rst_out_count", 64'(cnt_o[0]), 64'd0);
        chk("rst_ready_ena0", 64'(in_ready_o[0]), 64'd0);
        ena = 1'b1;
        @(negedge clk);
        chk("rst_ready_ena1", 64'(in_ready_o[0]), 64'd1);
        tick();
        reset = 1'b1;
        out_ready = 1'b1;
        tick();

        // 8 x (5*1) back to back, latency and one-cycle valid
        for (int i = 0; i < 8; i++) send(16'd5, 16'd1, 1'b0);
        @(negedge clk);
        chk("lat_flush_valid", 64'(out_valid_o[0]), 64'd0);
        @(negedge clk);
        chk("lat_valid", 64'(out_valid_o[0]), 64'd1);
        chk("lat_res", 64'(acc_o[0]), 64'd40);
        chk("lat_count", 64'(cnt_o[0]), 64'd8);
        chk("lat_ovf", 64'(ovf_o[0]), 64'd0);
        @(negedge clk);
        chk("lat_valid_drop", 64'(out_valid_o[0]), 64'd0);
        tick();

        // signed negative, early termination
        for (int i = 0; i < 4; i++) send(16'hFFFD, 16'd7, i == 3);
        expect_out(32'hFFFF_FFAC, 32'hFFFF_FFAC, 32'h001B_FFAC, 1'b0, 1'b0, 1'b0, 4);
        tick();

        // full-scale overflow: clamp vs wrap
        for (int i = 0; i < 8; i++) send(16'h7FFF, 16'h7FFF, 1'b0);
        expect_out(32'h7FFF_FFFF, 32'hFFF8_0008, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 8);
        tick();

        // backpressure
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(16'd4, 16'd4, 1'b0);
        expect_out(32'd128, 32'd128, 32'd128, 1'b0, 1'b0, 1'b0, 8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 64'(out_valid_o[0]), 64'd1);
            chk("bp_ready", 64'(in_ready_o[0]), 64'd0);
            chk("bp_res", 64'(acc_o[0]), 64'd128);
            chk("bp_count", 64'(cnt_o[0]), 64'd8);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(16'd2, 16'd3, 1'b0);
        expect_out(32'd48, 32'd48, 32'd48, 1'b0, 1'b0, 1'b0, 8);
        tick();

        // ena low for 3 cycles while in_valid stays high
        k = 16'd5; x = 16'd1; in_last = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 11; i++) begin
            ena = !(i >= 3 && i < 6);
            if (i == 4) begin
                @(negedge clk);
                chk("ena_low_ready", 64'(in_ready_o[0]), 64'd0);
            end
            tick();
        end
        ena = 1'b1;
        in_valid = 1'b0;
        expect_out(32'd40, 32'd40, 32'd40, 1'b0, 1'b0, 1'b0, 8);
        tick();

        // reset mid-frame
        for (int i = 0; i < 3; i++) send(16'd9, 16'd9, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 64'(out_valid_o[0]), 64'd0);
        chk("midrst_res", 64'(acc_o[0]), 64'd0);
        chk("midrst_count", 64'(cnt_o[0]), 64'd0);
        tick();
        reset = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) send(16'd1, 16'd1, 1'b0);
        expect_out(32'd8, 32'd8, 32'd8, 1'b0, 1'b0, 1'b0, 8);
        tick();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int sel;
            ena       = ($urandom % 10) != 0;
            in_valid  = ($urandom % 10) < 7;
            in_last   = ($urandom % 8) == 0;
            out_ready = ($urandom % 10) < 6;
            reset     = ($urandom % 400) != 0;
            sel = $urandom % 4;
            k = (sel == 0) ? 16'h7FFF : (sel == 1) ? 16'h8000 : 16'($urandom);
            sel = $urandom % 4;
            x = (sel == 0) ? 16'h7FFF : (sel == 1) ? 16'hFFFF : 16'($urandom);
            tick();
        end
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        ena = 1'b1;
        repeat (5) tick();
        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
